div_seq: RTL and testbench

Parametrised, multi-cycle iterative divider for the multiply/divide unit. It divides a WIDTH-bit dividend by a WIDTH-bit divisor, in signed or unsigned mode, and produces quotient, remainder and a divide-by-zero exception. It replaces the fixed 32-bit signed-only divider and adds a start/busy/done handshake, unsigned mode, a defined overflow result and a defined remainder sign. It sits beside the multiplier and is started by the same one-cycle control strobe from decode.

---
 rtl/div_seq.sv | 177 +++++++++++++++++
 tb/tb_div_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider, signed or unsigned, with start/busy/done handshake.
// One quotient bit per cycle; signs are stripped on entry and re-applied in a FIX cycle.
// Optional macro DIV_EARLY_ZERO_EN: a zero divisor completes straight from the start edge
// instead of running the full iteration.
module div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ctrl_DIV,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] divid,
    input  logic [WIDTH-1:0] divis,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             exceptRes
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    state_e state_q, state_d;
    logic   busy_q, busy_d, done_q, done_d;

    logic [WIDTH-1:0] dvd_sh_q, dvd_sh_d;    // dividend magnitude, consumed MSB first
    logic [WIDTH-1:0] divid_q, divid_d;      // original dividend, returned on divide-by-zero
    logic [WIDTH-1:0] dvs_mag_q, dvs_mag_d;
    logic [WIDTH-1:0] rem_acc_q, rem_acc_d;
    logic [WIDTH-1:0] quo_acc_q, quo_acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             neg_q_q, neg_q_d, neg_r_q, neg_r_d;
    logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
    logic             exc_q, exc_d;

    logic             start;
    logic             early_zero;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH:0]   rem_sh, diff;

    // Start is accepted only when no operation is in flight.
    assign start = ctrl_DIV && ((state_q == StIdle) || (state_q == StDone));

`ifdef DIV_EARLY_ZERO_EN
    assign early_zero = start && (divis == '0);
`else
    assign early_zero = 1'b0;
`endif

    assign dvd_mag = (is_signed && divid[WIDTH-1]) ? ({WIDTH{1'b0}} - divid) : divid;
    assign dvs_mag = (is_signed && divis[WIDTH-1]) ? ({WIDTH{1'b0}} - divis) : divis;

    // Restoring step: bring in next dividend bit, trial-subtract over WIDTH+1 bits.
    assign rem_sh = {rem_acc_q, dvd_sh_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dvs_mag_q};

    // State and handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = early_zero ? StDone : StRun;
            StRun:   if (cnt_q == LastCnt) state_d = StFix;
            StFix:   state_d = StDone;
            StDone:  state_d = start ? (early_zero ? StDone : StRun) : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs trail the state by one cycle so done never overlaps busy.
    always_comb begin
        busy_d = (state_q == StRun) || (state_q == StFix);
        done_d = (state_q == StDone);
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_sh_q  <= '0;
            divid_q   <= '0;
            dvs_mag_q <= '0;
            rem_acc_q <= '0;
            quo_acc_q <= '0;
            cnt_q     <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            exc_q     <= 1'b0;
        end else begin
            dvd_sh_q  <= dvd_sh_d;
            divid_q   <= divid_d;
            dvs_mag_q <= dvs_mag_d;
            rem_acc_q <= rem_acc_d;
            quo_acc_q <= quo_acc_d;
            cnt_q     <= cnt_d;
            neg_q_q   <= neg_q_d;
            neg_r_q   <= neg_r_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            exc_q     <= exc_d;
        end
    end

    // Datapath next-state: latch on start, iterate in RUN, sign-fix and publish in FIX.
    always_comb begin
        dvd_sh_d  = dvd_sh_q;
        divid_d   = divid_q;
        dvs_mag_d = dvs_mag_q;
        rem_acc_d = rem_acc_q;
        quo_acc_d = quo_acc_q;
        cnt_d     = cnt_q;
        neg_q_d   = neg_q_q;
        neg_r_d   = neg_r_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        exc_d     = exc_q;
        if (start) begin
            dvd_sh_d  = dvd_mag;
            divid_d   = divid;
            dvs_mag_d = dvs_mag;
            neg_q_d   = is_signed && (divid[WIDTH-1] ^ divis[WIDTH-1]);
            neg_r_d   = is_signed && divid[WIDTH-1];
            rem_acc_d = '0;
            quo_acc_d = '0;
            cnt_d     = '0;
            if (early_zero) begin
                quot_d = '0;
                rem_d  = divid;
                exc_d  = 1'b1;
            end
        end else if (state_q == StRun) begin
            dvd_sh_d = {dvd_sh_q[WIDTH-2:0], 1'b0};
            if (!diff[WIDTH]) begin
                rem_acc_d = diff[WIDTH-1:0];
                quo_acc_d = {quo_acc_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_acc_d = rem_sh[WIDTH-1:0];
                quo_acc_d = {quo_acc_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CntW'(1);
        end else if (state_q == StFix) begin
            if (dvs_mag_q == '0) begin
                quot_d = '0;
                rem_d  = divid_q;
                exc_d  = 1'b1;
            end else begin
                // MIN / -1 wraps back to MIN through the modular negation.
                quot_d = neg_q_q ? ({WIDTH{1'b0}} - quo_acc_q) : quo_acc_q;
                rem_d  = neg_r_q ? ({WIDTH{1'b0}} - rem_acc_q) : rem_acc_q;
                exc_d  = 1'b0;
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quot      = quot_q;
    assign rem       = rem_q;
    assign exceptRes = exc_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: a 32-bit instance for arithmetic/handshake and an 8-bit
// instance for the narrow build and mid-operation reset.
module tb_div_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        rst_n_a = 1'b0, ctrl_a = 1'b0, sgn_a = 1'b0;
    logic [31:0] divid_a = '0, divis_a = '0;
    logic        busy_a, done_a, exc_a;
    logic [31:0] quot_a, rem_a;

    // 8-bit instance
    logic        rst_n_b = 1'b0, ctrl_b = 1'b0, sgn_b = 1'b0;
    logic [7:0]  divid_b = '0, divis_b = '0;
    logic        busy_b, done_b, exc_b;
    logic [7:0]  quot_b, rem_b;

    div_seq #(.WIDTH(32)) u_dut_a (
        .clk(clk), .rst_n(rst_n_a), .ctrl_DIV(ctrl_a), .is_signed(sgn_a),
        .divid(divid_a), .divis(divis_a), .busy(busy_a), .done(done_a),
        .quot(quot_a), .rem(rem_a), .exceptRes(exc_a)
    );

    div_seq #(.WIDTH(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .ctrl_DIV(ctrl_b), .is_signed(sgn_b),
        .divid(divid_b), .divis(divis_b), .busy(busy_b), .done(done_b),
        .quot(quot_b), .rem(rem_b), .exceptRes(exc_b)
    );

`ifdef DIV_EARLY_ZERO_EN
    localparam int ZeroLat  = 1;
    localparam int ZeroBusy = 0;
`else
    localparam int ZeroLat  = 34;
    localparam int ZeroBusy = 33;
`endif

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a start strobe for one cycle; returns at the negedge after the sampling edge.
    task automatic start_a(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        sgn_a = s; divid_a = a; divis_a = b; ctrl_a = 1'b1;
        @(negedge clk);
        ctrl_a = 1'b0;
    endtask

    // Count negedges until done; optionally pulse a 9/3 start at cycle inj.
    task automatic wait_done_a(input int inj, output int lat, output int bcnt);
        lat  = -1;
        bcnt = busy_a ? 1 : 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n == inj) begin
                sgn_a = 1'b0; divid_a = 32'd9; divis_a = 32'd3; ctrl_a = 1'b1;
            end else if (n == inj + 1) begin
                ctrl_a = 1'b0;
            end
            if (done_a) begin
                lat = n;
                check("no_busy_with_done", {63'd0, busy_a}, 64'd0);
                break;
            end
            if (busy_a) bcnt++;
        end
    endtask

    task automatic run_a(input string tag, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                         input logic ex, input int elat, input int ebusy);
        int lat, bc;
        start_a(s, a, b);
        wait_done_a(-1, lat, bc);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_busy"}, bc, ebusy);
        check({tag, "_quot"}, {32'd0, quot_a}, {32'd0, eq});
        check({tag, "_rem"}, {32'd0, rem_a}, {32'd0, er});
        check({tag, "_exc"}, {63'd0, exc_a}, {63'd0, ex});
        @(negedge clk);
        check({tag, "_done_pulse"}, {63'd0, done_a}, 64'd0);
    endtask

    initial begin
        int lat, bc, dones;

        // Reset state
        @(negedge clk);
        check("rst_busy", {63'd0, busy_a}, 64'd0);
        check("rst_done", {63'd0, done_a}, 64'd0);
        check("rst_quot", {32'd0, quot_a}, 64'd0);
        check("rst_rem", {32'd0, rem_a}, 64'd0);
        check("rst_exc", {63'd0, exc_a}, 64'd0);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;

        run_a("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 33);
        run_a("sm100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34, 33);
        run_a("s100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 34, 33);
        run_a("umax_2", 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 1'b0, 34, 33);
        run_a("ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34, 33);
        run_a("zero", 1'b0, 32'h1234, 32'd0, 32'd0, 32'h1234, 1'b0 | 1'b1, ZeroLat, ZeroBusy);
        run_a("szero", 1'b1, 32'hFFFF_FF00, 32'd0, 32'd0, 32'hFFFF_FF00, 1'b1, ZeroLat, ZeroBusy);
        run_a("after_zero", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 34, 33);

        // Start ignored mid-run, then restart in the done cycle
        start_a(1'b0, 32'd100, 32'd7);
        wait_done_a(10, lat, bc);
        check("ign_lat", lat, 34);
        check("ign_quot", {32'd0, quot_a}, 64'd14);
        check("ign_rem", {32'd0, rem_a}, 64'd2);
        sgn_a = 1'b0; divid_a = 32'd9; divis_a = 32'd3; ctrl_a = 1'b1;
        @(negedge clk);
        ctrl_a = 1'b0;
        check("b2b_done_pulse", {63'd0, done_a}, 64'd0);
        check("b2b_hold_quot", {32'd0, quot_a}, 64'd14);
        wait_done_a(-1, lat, bc);
        check("b2b_lat", lat, 34);
        check("b2b_quot", {32'd0, quot_a}, 64'd3);
        check("b2b_rem", {32'd0, rem_a}, 64'd0);

        // 8-bit build: 200/13
        @(negedge clk);
        sgn_b = 1'b0; divid_b = 8'd200; divis_b = 8'd13; ctrl_b = 1'b1;
        @(negedge clk);
        ctrl_b = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done_b) begin
                lat = n;
                break;
            end
        end
        check("w8_lat", lat, 10);
        check("w8_quot", {56'd0, quot_b}, 64'd15);
        check("w8_rem", {56'd0, rem_b}, 64'd5);

        // 8-bit: reset in the middle of RUN
        @(negedge clk);
        divid_b = 8'd100; divis_b = 8'd7; ctrl_b = 1'b1;
        @(negedge clk);
        ctrl_b = 1'b0;
        repeat (3) @(negedge clk);
        check("w8_busy_before_rst", {63'd0, busy_b}, 64'd1);
        rst_n_b = 1'b0;
        #1;
        check("w8_rst_busy", {63'd0, busy_b}, 64'd0);
        check("w8_rst_done", {63'd0, done_b}, 64'd0);
        check("w8_rst_quot", {56'd0, quot_b}, 64'd0);
        check("w8_rst_rem", {56'd0, rem_b}, 64'd0);
        check("w8_rst_exc", {63'd0, exc_b}, 64'd0);
        @(negedge clk);
        rst_n_b = 1'b1;
        dones = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done_b || busy_b) dones++;
        end
        check("w8_no_done_after_rst", dones, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
